// File: rtl/muldiv_pkg.sv
// Shared types and default sizes for the multiply/divide writeback merge stage.
package muldiv_pkg;

    localparam int MUL_DEPTH_DEF = 4;
    localparam int DIV_DEPTH_DEF = 2;
    localparam int PHYS_W_DEF    = 7;
    localparam int ROB_W_DEF     = 8;

    typedef enum logic {
        WB_SRC_MUL = 1'b0,
        WB_SRC_DIV = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [63:0]           result;
        logic [PHYS_W_DEF-1:0] dest_phys;
        logic [ROB_W_DEF-1:0]  rob_idx;
    } wb_entry_t;

endpackage

// File: rtl/muldiv_wb_fifo.sv
// Small result FIFO with explicit modulo-DEPTH pointers (DEPTH need not be a power of two).
// A push to a full FIFO without a same-cycle pop is dropped and flagged on drop_err.
module muldiv_wb_fifo
    import muldiv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      empty,
    output logic      full,
    output logic      drop_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop_err = push && full && !do_pop;
    assign head     = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Payload storage is not reset; the top level zeroes wb_* whenever nothing is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Merges multiply and divide results onto one ready/valid writeback port, round-robin,
// with per-path issue credits. Define MULDIV_WB_BYPASS_EN for a 0-cycle empty-FIFO bypass.
module muldiv_wb_arbiter
    import muldiv_pkg::*;
#(
    parameter int MUL_DEPTH = MUL_DEPTH_DEF,
    parameter int DIV_DEPTH = DIV_DEPTH_DEF,
    parameter int PHYS_W    = PHYS_W_DEF,
    parameter int ROB_W     = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_issue_i,
    input  logic              div_issue_i,
    output logic              mul_credit_o,
    output logic              div_credit_o,
    input  logic              mul_valid_i,
    input  logic [63:0]       mul_result_i,
    input  logic [PHYS_W-1:0] mul_dest_phys_i,
    input  logic [ROB_W-1:0]  mul_rob_idx_i,
    input  logic              div_valid_i,
    input  logic [63:0]       div_result_i,
    input  logic [PHYS_W-1:0] div_dest_phys_i,
    input  logic [ROB_W-1:0]  div_rob_idx_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [63:0]       wb_result_o,
    output logic [PHYS_W-1:0] wb_dest_phys_o,
    output logic [ROB_W-1:0]  wb_rob_idx_o,
    output logic              wb_src_o,
    output logic              overflow_o
);

    localparam int MUL_CW = $clog2(MUL_DEPTH + 1);
    localparam int DIV_CW = $clog2(DIV_DEPTH + 1);

    wb_entry_t         mul_in, div_in, mul_head, div_head, sel;
    logic              mul_empty, div_empty, mul_full, div_full, mul_drop, div_drop;
    logic              mul_push, div_push, mul_pop, div_pop;
    logic              byp_mul, byp_div, mul_avail, div_avail, grant_div;
    logic              xfer, mul_xfer, div_xfer;
    logic              hold_q, overflow_q;
    wb_src_e           last_grant_q, held_src_q;
    logic [MUL_CW-1:0] mul_out_q;
    logic [DIV_CW-1:0] div_out_q;
    logic              unused_full;

    assign mul_in = '{result: mul_result_i, dest_phys: mul_dest_phys_i, rob_idx: mul_rob_idx_i};
    assign div_in = '{result: div_result_i, dest_phys: div_dest_phys_i, rob_idx: div_rob_idx_i};

`ifdef MULDIV_WB_BYPASS_EN
    assign byp_mul = mul_valid_i && mul_empty && div_empty;
    assign byp_div = div_valid_i && mul_empty && div_empty;
`else
    assign byp_mul = 1'b0;
    assign byp_div = 1'b0;
`endif

    // A presented-but-unaccepted entry locks the grant so the payload cannot change under the consumer.
    always_comb begin
        mul_avail  = !mul_empty || byp_mul;
        div_avail  = !div_empty || byp_div;
        if (hold_q)                      grant_div = (held_src_q == WB_SRC_DIV);
        else if (mul_avail && div_avail) grant_div = (last_grant_q == WB_SRC_MUL);
        else                             grant_div = div_avail;
        wb_valid_o = mul_avail || div_avail;
`ifdef MULDIV_WB_BYPASS_EN
        if (grant_div) sel = div_empty ? div_in : div_head;
        else           sel = mul_empty ? mul_in : mul_head;
`else
        sel = grant_div ? div_head : mul_head;
`endif
        if (!wb_valid_o) sel = '0;
    end

    assign wb_result_o    = sel.result;
    assign wb_dest_phys_o = sel.dest_phys;
    assign wb_rob_idx_o   = sel.rob_idx;
    assign wb_src_o       = wb_valid_o && grant_div;

    assign xfer     = wb_valid_o && wb_ready_i;
    assign mul_xfer = xfer && !grant_div;
    assign div_xfer = xfer && grant_div;
    assign mul_pop  = mul_xfer && !mul_empty;
    assign div_pop  = div_xfer && !div_empty;
    assign mul_push = mul_valid_i && !(mul_xfer && mul_empty);
    assign div_push = div_valid_i && !(div_xfer && div_empty);

    // Full flags are informational here; overflow is taken from the FIFOs' drop pulses.
    assign unused_full = mul_full ^ div_full;

    muldiv_wb_fifo #(.DEPTH(MUL_DEPTH)) u_mul_fifo (
        .clk(clk), .rst_n(rst_n), .push(mul_push), .pop(mul_pop), .din(mul_in),
        .head(mul_head), .empty(mul_empty), .full(mul_full), .drop_err(mul_drop)
    );

    muldiv_wb_fifo #(.DEPTH(DIV_DEPTH)) u_div_fifo (
        .clk(clk), .rst_n(rst_n), .push(div_push), .pop(div_pop), .din(div_in),
        .head(div_head), .empty(div_empty), .full(div_full), .drop_err(div_drop)
    );

    assign mul_credit_o = (mul_out_q < MUL_CW'(MUL_DEPTH));
    assign div_credit_o = (div_out_q < DIV_CW'(DIV_DEPTH));
    assign overflow_o   = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_out_q <= '0;
        end else if (mul_issue_i && !mul_xfer) begin
            if (mul_credit_o) mul_out_q <= mul_out_q + 1'b1;
        end else if (mul_xfer && !mul_issue_i && mul_out_q != '0) begin
            mul_out_q <= mul_out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_out_q <= '0;
        end else if (div_issue_i && !div_xfer) begin
            if (div_credit_o) div_out_q <= div_out_q + 1'b1;
        end else if (div_xfer && !div_issue_i && div_out_q != '0) begin
            div_out_q <= div_out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= WB_SRC_DIV;
            held_src_q   <= WB_SRC_MUL;
            hold_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (xfer) last_grant_q <= wb_src_e'(grant_div);
            hold_q     <= wb_valid_o && !wb_ready_i;
            held_src_q <= wb_src_e'(grant_div);
            if ((mul_issue_i && !mul_credit_o) || (div_issue_i && !div_credit_o) ||
                mul_drop || div_drop)
                overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed bench for muldiv_wb_arbiter: scoreboard of expected writebacks plus per-step checks.
module tb_muldiv_wb_arbiter;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_issue_i, div_issue_i, mul_credit_o, div_credit_o;
    logic        mul_valid_i, div_valid_i;
    logic [63:0] mul_result_i, div_result_i;
    logic [6:0]  mul_dest_phys_i, div_dest_phys_i;
    logic [7:0]  mul_rob_idx_i, div_rob_idx_i;
    logic        wb_valid_o, wb_ready_i, wb_src_o, overflow_o;
    logic [63:0] wb_result_o;
    logic [6:0]  wb_dest_phys_o;
    logic [7:0]  wb_rob_idx_o;

    int          checks = 0;
    int          errors = 0;
    logic [79:0] exp_q[$];
    logic [79:0] mon_e;

    always #5 clk = ~clk;

    muldiv_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .mul_issue_i(mul_issue_i), .div_issue_i(div_issue_i),
        .mul_credit_o(mul_credit_o), .div_credit_o(div_credit_o),
        .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
        .mul_dest_phys_i(mul_dest_phys_i), .mul_rob_idx_i(mul_rob_idx_i),
        .div_valid_i(div_valid_i), .div_result_i(div_result_i),
        .div_dest_phys_i(div_dest_phys_i), .div_rob_idx_i(div_rob_idx_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_result_o(wb_result_o), .wb_dest_phys_o(wb_dest_phys_o),
        .wb_rob_idx_o(wb_rob_idx_o), .wb_src_o(wb_src_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] wb_obs();
        return {wb_result_o, wb_dest_phys_o, wb_rob_idx_o, wb_src_o};
    endfunction

    task automatic exp_push(input logic [63:0] r, input logic [6:0] d, input logic [7:0] rob,
                            input logic src);
        exp_q.push_back({r, d, rob, src});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mul(input logic v, input logic [63:0] r, input logic [6:0] d,
                           input logic [7:0] rob);
        mul_valid_i = v; mul_result_i = r; mul_dest_phys_i = d; mul_rob_idx_i = rob;
    endtask

    task automatic set_div(input logic v, input logic [63:0] r, input logic [6:0] d,
                           input logic [7:0] rob);
        div_valid_i = v; div_result_i = r; div_dest_phys_i = d; div_rob_idx_i = rob;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        repeat (2) step();
        chk(tag, 96'(exp_q.size()), 96'd0);
    endtask

    // Scoreboard: every accepted writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && wb_valid_o && wb_ready_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed rob=%0d src=%0d, expected no transfer",
                       wb_rob_idx_o, wb_src_o);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wb_order", {16'd0, wb_obs()}, {16'd0, mon_e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mul_issue_i = 1'b0; div_issue_i = 1'b0; wb_ready_i = 1'b0;
        set_mul(0, 0, 0, 0);
        set_div(0, 0, 0, 0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_wb", {15'd0, wb_valid_o, wb_obs()}, 96'd0);
        chk("reset_flags", {93'd0, overflow_o, mul_credit_o, div_credit_o}, 96'd3);
        step();
        rst_n = 1'b1;
        step();

        // Single multiply
        mul_issue_i = 1'b1; wb_ready_i = 1'b1;
        step();
        mul_issue_i = 1'b0;
        set_mul(1, 64'h1234, 7'd5, 8'd9);
        exp_push(64'h1234, 7'd5, 8'd9, 1'b0);
        @(negedge clk);
`ifdef MULDIV_WB_BYPASS_EN
        chk("single_bypass", {15'd0, wb_valid_o, wb_obs()}, {15'd0, 1'b1, 64'h1234, 7'd5, 8'd9, 1'b0});
`else
        chk("single_latency", {95'd0, wb_valid_o}, 96'd0);
`endif
        step();
        set_mul(0, 0, 0, 0);
        @(negedge clk);
`ifdef MULDIV_WB_BYPASS_EN
        chk("single_fifo_empty", {95'd0, wb_valid_o}, 96'd0);
`else
        chk("single_wb", {15'd0, wb_valid_o, wb_obs()}, {15'd0, 1'b1, 64'h1234, 7'd5, 8'd9, 1'b0});
`endif
        step();
        @(negedge clk);
        chk("single_after", {94'd0, wb_valid_o, mul_credit_o}, 96'd1);

        // Reset mid-stream with three multiplies buffered
        step();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mul_issue_i = 1'b1;
            set_mul(1, 64'h300 + 64'(i), 7'(i), 8'(30 + i));
            step();
        end
        mul_issue_i = 1'b0;
        set_mul(0, 0, 0, 0);
        @(negedge clk);
        chk("prereset_head", {87'd0, wb_valid_o, wb_rob_idx_o}, {87'd0, 1'b1, 8'd30});
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("reset_async_wb", {15'd0, wb_valid_o, wb_obs()}, 96'd0);
        chk("reset_async_flags", {93'd0, overflow_o, mul_credit_o, div_credit_o}, 96'd3);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_reset", {93'd0, wb_valid_o, mul_credit_o, div_credit_o}, 96'd3);
        step();

        // Contention from fresh state: multiply wins first
        wb_ready_i = 1'b1;
        mul_issue_i = 1'b1; div_issue_i = 1'b1;
        set_mul(1, 64'hA1, 7'd1, 8'd1);
        set_div(1, 64'hB2, 7'd2, 8'd2);
        exp_push(64'hA1, 7'd1, 8'd1, 1'b0);
        exp_push(64'hB2, 7'd2, 8'd2, 1'b1);
        @(negedge clk);
`ifdef MULDIV_WB_BYPASS_EN
        chk("coll1_c0", {86'd0, wb_valid_o, wb_src_o, wb_rob_idx_o}, {86'd0, 1'b1, 1'b0, 8'd1});
`else
        chk("coll1_c0", {95'd0, wb_valid_o}, 96'd0);
`endif
        step();
        mul_issue_i = 1'b0; div_issue_i = 1'b0;
        set_mul(0, 0, 0, 0);
        set_div(0, 0, 0, 0);
        @(negedge clk);
`ifdef MULDIV_WB_BYPASS_EN
        chk("coll1_c1", {86'd0, wb_valid_o, wb_src_o, wb_rob_idx_o}, {86'd0, 1'b1, 1'b1, 8'd2});
`else
        chk("coll1_c1", {86'd0, wb_valid_o, wb_src_o, wb_rob_idx_o}, {86'd0, 1'b1, 1'b0, 8'd1});
`endif
        step();
        @(negedge clk);
`ifdef MULDIV_WB_BYPASS_EN
        chk("coll1_c2", {86'd0, wb_valid_o, wb_src_o, wb_rob_idx_o}, 96'd0);
`else
        chk("coll1_c2", {86'd0, wb_valid_o, wb_src_o, wb_rob_idx_o}, {86'd0, 1'b1, 1'b1, 8'd2});
`endif
        drain("coll1_drain");

        // Lone multiply leaves last grant on multiply; the next collision goes to divide first
        mul_issue_i = 1'b1;
        set_mul(1, 64'hC3, 7'd3, 8'd3);
        exp_push(64'hC3, 7'd3, 8'd3, 1'b0);
        step();
        mul_issue_i = 1'b0;
        set_mul(0, 0, 0, 0);
        step();
        mul_issue_i = 1'b1; div_issue_i = 1'b1;
        set_mul(1, 64'hC4, 7'd4, 8'd4);
        set_div(1, 64'hC5, 7'd5, 8'd5);
        exp_push(64'hC5, 7'd5, 8'd5, 1'b1);
        exp_push(64'hC4, 7'd4, 8'd4, 1'b0);
        step();
        mul_issue_i = 1'b0; div_issue_i = 1'b0;
        set_mul(0, 0, 0, 0);
        set_div(0, 0, 0, 0);
        drain("coll2_drain");

        // Backpressure: credits run out, payload holds, then drains in order
        wb_ready_i = 1'b0;
        mul_issue_i = 1'b1;
        repeat (4) step();
        mul_issue_i = 1'b0;
        @(negedge clk);
        chk("credit_exhausted", {94'd0, mul_credit_o, div_credit_o}, 96'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            set_mul(1, 64'h100 + 64'(i), 7'(10 + i), 8'(10 + i));
            exp_push(64'h100 + 64'(i), 7'(10 + i), 8'(10 + i), 1'b0);
            step();
        end
        set_mul(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", {15'd0, wb_valid_o, wb_obs()}, {15'd0, 1'b1, 64'h100, 7'd10, 8'd10, 1'b0});
            step();
        end
        chk("stall_no_overflow", {95'd0, overflow_o}, 96'd0);
        wb_ready_i = 1'b1;
        set_mul(1, 64'h104, 7'd14, 8'd14);
        exp_push(64'h104, 7'd14, 8'd14, 1'b0);
        step();
        set_mul(0, 0, 0, 0);
        drain("bp_drain");
        @(negedge clk);
        chk("bp_credit_back", {93'd0, wb_valid_o, overflow_o, mul_credit_o}, 96'd1);
        step();

        // Overflow: issue without credit, then push into a full divide FIFO
        wb_ready_i = 1'b0;
        div_issue_i = 1'b1;
        repeat (2) step();
        div_issue_i = 1'b0;
        @(negedge clk);
        chk("div_credit_exhausted", {94'd0, div_credit_o, overflow_o}, 96'd0);
        step();
        div_issue_i = 1'b1;
        step();
        div_issue_i = 1'b0;
        @(negedge clk);
        chk("ovf_issue", {94'd0, overflow_o, div_credit_o}, 96'd2);
        step();
        set_div(1, 64'h200, 7'd20, 8'd20);
        exp_push(64'h200, 7'd20, 8'd20, 1'b1);
        step();
        set_div(1, 64'h201, 7'd21, 8'd21);
        exp_push(64'h201, 7'd21, 8'd21, 1'b1);
        step();
        set_div(1, 64'hDEAD, 7'd22, 8'd22);
        step();
        set_div(0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        chk("ovf_head", {14'd0, overflow_o, wb_valid_o, wb_obs()},
            {14'd0, 1'b1, 1'b1, 64'h200, 7'd20, 8'd20, 1'b1});
        step();
        wb_ready_i = 1'b1;
        drain("ovf_drain");
        @(negedge clk);
        chk("ovf_sticky", {93'd0, overflow_o, wb_valid_o, div_credit_o}, 96'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
